// File: rtl/rs232_pkg.sv
// rs232_pkg
//   Shared definitions for the RS232 transmit path: controller state encoding,
//   payload width, frame slot count and the sequencer idle code.
//   No ports.
package rs232_pkg;

  localparam int RS232_DATA_W      = 8;
  // start + 8 data + parity + stop
  localparam int RS232_FRAME_SLOTS = 11;
  // sequencer slot counter value meaning "no frame in flight"
  localparam int RS232_SEQ_IDLE    = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } rs232_tx_state_e;

endpackage

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo
//   Synchronous FIFO buffering host bytes ahead of the frame launcher.
//   Ports:
//     CLK, RST         clock (rising edge), async active-high reset
//     push, wr_data    write request and byte; ignored while full
//     pop              remove head entry (caller guarantees count != 0)
//     rd_data          current head entry
//     count            occupancy 0..DEPTH
//     full             count == DEPTH
module rs232_tx_fifo import rs232_pkg::*; #(
  parameter  int DATA_W = RS232_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;

  // full comes from the registered count, so a push on the pop edge of a
  // full FIFO is still refused
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rs232_tx_feeder.sv
// rs232_tx_feeder
//   Upstream stage of the RS232 transmit frame sequencer. Buffers host bytes
//   and launches one frame per byte with a single-cycle STT pulse, holding
//   TX_DATA/TX_PAR stable until the next launch.
//   Build option: RS232_TX_PARITY_EN -> TX_PAR is the even parity of the
//   launched byte; otherwise TX_PAR is tied to mark (1).
//   Ports:
//     CLK, RST        clock (rising edge), async active-high reset
//     WR_EN, WR_DATA  host write strobe and byte
//     FULL, OVF       FIFO full; sticky overflow (cleared only by RST)
//     COUNT           FIFO occupancy
//     BUSY            controller not idle or FIFO not empty
//     STT             start pulse to the sequencer
//     EOT             sequencer idle indication (1 = idle)
//     TX_DATA, TX_PAR byte and parity of the frame in flight
//
// state        | meaning
// ST_IDLE      | waiting for a queued byte and an idle sequencer
// ST_START     | STT high this cycle; sequencer samples it on the next edge
// ST_WAIT_ACK  | waiting for EOT to drop (frame started)
// ST_WAIT_DONE | waiting for EOT to return (frame finished)
module rs232_tx_feeder import rs232_pkg::*; #(
  parameter  int DATA_W = RS232_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              FULL,
  output logic              OVF,
  output logic [CNT_W-1:0]  COUNT,
  output logic              BUSY,
  output logic              STT,
  input  logic              EOT,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_PAR
);

  rs232_tx_state_e   state;
  rs232_tx_state_e   state_nxt;
  logic              pop;
  logic              push;
  logic              stt_nxt;
  logic              stt_q;
  logic              ovf_q;
  logic              busy_q;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tx_data_q;
  logic [CNT_W-1:0]  count_nxt;

  rs232_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (WR_EN),
    .wr_data (WR_DATA),
    .pop     (pop),
    .rd_data (head),
    .count   (COUNT),
    .full    (FULL)
  );

  // mirrors the FIFO's acceptance rule so BUSY can be registered
  assign push      = WR_EN && !FULL;
  assign count_nxt = COUNT + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_nxt = state;
    stt_nxt   = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((COUNT != '0) && EOT) begin
          pop       = 1'b1;
          stt_nxt   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!EOT) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (EOT)  state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      stt_q     <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state  <= state_nxt;
      stt_q  <= stt_nxt;
      ovf_q  <= ovf_q | (WR_EN & FULL);
      busy_q <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      if (pop) tx_data_q <= head;
    end
  end

`ifdef RS232_TX_PARITY_EN
  logic tx_par_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      tx_par_q <= 1'b1;
    else if (pop) tx_par_q <= ^head;
  end

  assign TX_PAR = tx_par_q;
`else
  assign TX_PAR = 1'b1;
`endif

  assign STT     = stt_q;
  assign OVF     = ovf_q;
  assign BUSY    = busy_q;
  assign TX_DATA = tx_data_q;

endmodule

// File: tb/tb_rs232_tx_feeder.sv
// tb_rs232_tx_feeder
//   Directed bench for rs232_tx_feeder with a behavioural sequencer model
//   (slot counter 1..RS232_FRAME_SLOTS, EOT=1 when idle). The "hold" input
//   forces EOT low to emulate a sequencer kept busy.
module tb_rs232_tx_feeder;
  import rs232_pkg::*;

`ifdef RS232_TX_PARITY_EN
  localparam bit EXP_PAR_A5 = 1'b0;
`else
  localparam bit EXP_PAR_A5 = 1'b1;
`endif
  localparam bit EXP_PAR_07 = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, ovf, busy, stt, eot, tx_par;
  logic [2:0] count;
  logic [7:0] tx_data;
  logic [3:0] qp;
  logic       hold = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rs232_tx_feeder #(.DATA_W(8), .DEPTH(4)) dut (
    .CLK     (clk),
    .RST     (rst),
    .WR_EN   (wr_en),
    .WR_DATA (wr_data),
    .FULL    (full),
    .OVF     (ovf),
    .COUNT   (count),
    .BUSY    (busy),
    .STT     (stt),
    .EOT     (eot),
    .TX_DATA (tx_data),
    .TX_PAR  (tx_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                qp <= 4'(RS232_SEQ_IDLE);
    else if (qp == 4'(RS232_SEQ_IDLE))      begin if (stt) qp <= 4'd1; end
    else if (qp == 4'(RS232_FRAME_SLOTS))   qp <= 4'(RS232_SEQ_IDLE);
    else                                    qp <= qp + 4'd1;
  end

  assign eot = (qp == 4'(RS232_SEQ_IDLE)) && !hold;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_stt(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (stt === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({count, full, ovf, stt, tx_data, tx_par, busy} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_during got cnt=%0d full=%b ovf=%b stt=%b data=%h par=%b busy=%b", count, full, ovf, stt, tx_data, tx_par, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({count, full, ovf, stt, tx_data, tx_par, busy} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_after got cnt=%0d full=%b ovf=%b stt=%b data=%h par=%b busy=%b", count, full, ovf, stt, tx_data, tx_par, busy);
    end
  endtask

  task automatic test_single;
    write_byte(8'hA5);                       // edge n
    vectors++;
    if (count !== 3'd1 || stt !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_n got cnt=%0d stt=%b busy=%b want 1 0 1", count, stt, busy);
    end
    tick();                                  // edge n+1
    vectors++;
    if (stt !== 1'b1 || tx_data !== 8'hA5 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL single_n1 got stt=%b data=%h cnt=%0d want 1 a5 0", stt, tx_data, count);
    end
    vectors++;
    if (tx_par !== EXP_PAR_A5) begin
      miscompares++;
      $display("FAIL parity_a5 got %b want %b", tx_par, EXP_PAR_A5);
    end
    tick();                                  // edge n+2
    vectors++;
    if (stt !== 1'b0 || eot !== 1'b0) begin
      miscompares++;
      $display("FAIL single_n2 got stt=%b eot=%b want 0 0", stt, eot);
    end
    for (int k = 3; k <= 13; k++) begin
      tick();
      vectors++;
      if (tx_data !== 8'hA5 || stt !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_hold edge n+%0d got data=%h stt=%b busy=%b want a5 0 1", k, tx_data, stt, busy);
      end
    end
    tick();                                  // edge n+14
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_busy_fall got %b want 0", busy);
    end
  endtask

  task automatic test_fill_overflow;
    bit found;
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i));
      if (i == 4) begin
        vectors++;
        if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_4 got full=%b cnt=%0d ovf=%b want 1 4 0", full, count, ovf);
        end
      end
    end
    vectors++;
    if (ovf !== 1'b1 || count !== 3'd4 || stt !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_ovf got ovf=%b cnt=%0d stt=%b want 1 4 0", ovf, count, stt);
    end
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_stt(40, found);
      vectors++;
      if (!found || tx_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL fill_order frame %0d got found=%b data=%h want %h", i, found, tx_data, 8'(i));
      end
    end
    wait_stt(30, found);
    vectors++;
    if (found || ovf !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_drain got extra=%b ovf=%b cnt=%0d want 0 1 0", found, ovf, count);
    end
  endtask

  task automatic test_simul_push_pop;
    bit found;
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i));
    vectors++;
    if (count !== 3'd4 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_full_pre got cnt=%0d full=%b want 4 1", count, full);
    end
    hold = 1'b0;
    write_byte(8'h99);
    vectors++;
    if (stt !== 1'b1 || tx_data !== 8'h10 || count !== 3'd3 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_full got stt=%b data=%h cnt=%0d ovf=%b want 1 10 3 1", stt, tx_data, count, ovf);
    end
    for (int i = 1; i <= 3; i++) begin
      wait_stt(40, found);
      vectors++;
      if (!found || tx_data !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL simul_full_drain frame %0d got found=%b data=%h", i, found, tx_data);
      end
    end
    wait_stt(30, found);
    vectors++;
    if (found || count !== 3'd0) begin
      miscompares++;
      $display("FAIL simul_full_dropped got extra=%b cnt=%0d want 0 0", found, count);
    end

    do_reset();
    hold = 1'b1;
    write_byte(8'h20);
    write_byte(8'h21);
    hold = 1'b0;
    write_byte(8'h22);
    vectors++;
    if (stt !== 1'b1 || tx_data !== 8'h20 || count !== 3'd2 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_two got stt=%b data=%h cnt=%0d ovf=%b want 1 20 2 0", stt, tx_data, count, ovf);
    end
    for (int i = 1; i <= 2; i++) begin
      wait_stt(40, found);
      vectors++;
      if (!found || tx_data !== 8'h20 + 8'(i)) begin
        miscompares++;
        $display("FAIL simul_two_drain frame %0d got found=%b data=%h", i, found, tx_data);
      end
    end
    wait_stt(30, found);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    int  nframes = 0;
    int  ngaps = 0;
    int  gap = 0;
    bit  gap_open = 1'b0;
    bit  active = 1'b0;
    bit  prev_stt = 1'b0;
    exp_b[0] = 8'h3A; exp_b[1] = 8'h3B; exp_b[2] = 8'h3C;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(exp_b[i]);
    hold = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      vectors++;
      if ((stt === 1'b1 && eot !== 1'b1) || (stt === 1'b1 && prev_stt)) begin
        miscompares++;
        $display("FAIL b2b_stt cycle %0d got stt=%b eot=%b prev_stt=%b", c, stt, eot, prev_stt);
      end
      if (stt === 1'b1) begin
        if (nframes < 3) begin
          vectors++;
          if (tx_data !== exp_b[nframes]) begin
            miscompares++;
            $display("FAIL b2b_data frame %0d got %h want %h", nframes, tx_data, exp_b[nframes]);
          end
        end
        nframes++;
      end
      prev_stt = (stt === 1'b1);
      if (qp != 4'(RS232_SEQ_IDLE)) begin
        if (gap_open) begin
          vectors++;
          if (gap != 3) begin
            miscompares++;
            $display("FAIL b2b_gap got %0d idle cycles want 3", gap);
          end
          ngaps++;
        end
        gap_open = 1'b0;
        gap = 0;
        active = 1'b1;
      end else if (active) begin
        gap_open = 1'b1;
        gap++;
      end
    end
    vectors++;
    if (nframes != 3 || ngaps != 2) begin
      miscompares++;
      $display("FAIL b2b_counts got frames=%0d gaps=%0d want 3 2", nframes, ngaps);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit found;
    bit hit = 1'b0;
    hold = 1'b1;
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h43);
    hold = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if (qp == 4'd5) hit = 1'b1;
    end
    vectors++;
    if (!hit || count !== 3'd2) begin
      miscompares++;
      $display("FAIL midrst_setup got reached=%b cnt=%0d want 1 2", hit, count);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({count, stt, tx_data, busy, full, tx_par} !== {3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_clear got cnt=%0d stt=%b data=%h busy=%b full=%b par=%b", count, stt, tx_data, busy, full, tx_par);
    end
    tick();
    rst = 1'b0;
    wait_stt(30, found);
    vectors++;
    if (found || count !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_quiet got stt_seen=%b cnt=%0d want 0 0", found, count);
    end
    write_byte(8'h07);
    wait_stt(5, found);
    vectors++;
    if (!found || tx_data !== 8'h07 || tx_par !== EXP_PAR_07) begin
      miscompares++;
      $display("FAIL parity_07 got found=%b data=%h par=%b want 1 07 %b", found, tx_data, tx_par, EXP_PAR_07);
    end
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if (busy === 1'b0) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL midrst_final_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simul_push_pop();
    do_reset();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
